btb_assoc: RTL and testbench
============================

# btb_assoc

Parametrised set-associative branch target buffer for the fetch stage. It is the next generation of the direct-mapped BTB. It adds configurable sets, ways and tag width, a registered one-cycle lookup with stall hold, pseudo-LRU replacement, and entry invalidation. Fetch issues a lookup per PC. The backend issues a dispatch-time update with the resolved target. A sequenced sweep clears the array after reset and on flush.

## Interface
Parameters:
- SETS, 256: number of sets; power of two, 4..1024. IDX_W = log2(SETS).
- WAYS, 2: associativity; 1, 2 or 4.
- TAG_W, 12: stored tag width. IDX_W + 2 + TAG_W ≤ 32.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- lookup_valid  in  1  lookup request this cycle.
- lookup_pc  in  32  fetch PC.
- stall  in  1  hold lookup output register; new lookups not accepted.
- resp_valid  out  1  registered: response for the previous accepted lookup.
- resp_hit  out  1  registered: that lookup hit a valid matching entry.
- resp_target  out  32  registered: predicted target; 0 when resp_hit = 0.
- resp_way  out  log2(WAYS) (min 1)  registered: way that hit; 0 on miss.
- update_en  in  1  write or invalidate request.
- update_pc  in  32  branch PC.
- update_target  in  32  resolved target.
- update_clear  in  1  with update_en: invalidate matching entry instead of writing.
- flush_req  in  1  pulse: invalidate the whole array.
- busy  out  1  sweep in progress.

## Operation
- Address split:
  - index = pc[IDX_W+1:2].
  - tag = pc[IDX_W+2 +: TAG_W]; upper bits are ignored, so aliasing is accepted.
- Storage per set and way: valid bit, tag, target. Per set: PLRU state.
  - WAYS=1: no PLRU state.
  - WAYS=2: 1 bit, pointing at the LRU way.
  - WAYS=4: 3-bit tree PLRU.
  - The array has no reset. Valid and PLRU are cleared only by the sweep.
- FSM states: SWEEP, IDLE.
  - Reset puts the FSM in SWEEP with counter = 0.
  - SWEEP clears the valid bits and PLRU of one set per cycle, at set = counter. The counter wraps at SETS−1, after which the FSM goes to IDLE.
  - flush_req in IDLE enters SWEEP with counter = 0.
  - flush_req during SWEEP restarts the counter at 0.
  - busy = 1 exactly in SWEEP.
- Lookup, accepted when lookup_valid && !stall:
  - All ways of the set are compared.
  - Hit = valid && tag match. If several ways match, the lowest way index wins.
  - A lookup accepted during SWEEP returns resp_valid = 1 and resp_hit = 0.
  - Lookups do not modify PLRU.
- Update, when update_en && !busy:
  - Hit, update_clear = 0: overwrite that way's target and mark it MRU.
  - Hit, update_clear = 1: clear that way's valid bit; PLRU is unchanged.
  - Miss, update_clear = 0: the victim is the lowest-index invalid way, or the PLRU way if none is invalid. Write valid, tag and target, and mark the victim MRU.
  - Miss, update_clear = 1: no effect.
  - Update while busy: dropped, no effect.
- Simultaneous events:
  - A lookup reads array state from before a same-cycle update; there is no bypass.
  - flush_req takes priority over a same-cycle update, which is dropped.

## Timing
- Reset values:
  - resp_valid = 0, resp_hit = 0, resp_target = 0, resp_way = 0.
  - busy = 1 from reset assertion through the SETS cycles after deassertion.
- Lookup latency is 1 cycle: accepted at edge N, the response is visible after edge N+1.
- When no lookup is accepted and stall = 0, resp_valid = 0 next cycle. The other resp_* outputs then go to 0.
- When stall = 1, all resp_* registers hold their values.
- Update write latency is 1 cycle: an update at edge N is visible to a lookup accepted at edge N+1.
- Sweep length: the first IDLE cycle is SETS cycles after reset release or after the last flush_req.
- Reset asserted mid-sweep or mid-operation: outputs go to their reset values immediately; the sweep restarts from 0 after release.

## Test plan
- Reset release, SETS=256:
  - busy stays 1 for 256 cycles, then 0.
  - A lookup of 0x1C000000 at cycle 10 gives resp_valid = 1, resp_hit = 0.
  - An update at cycle 10 is dropped; a lookup after busy falls misses.
- Update then lookup:
  - Update pc 0x1C000100, target 0x1C000800.
  - A lookup of 0x1C000100 in the next cycle gives resp_hit = 1, resp_target = 0x1C000800, resp_way = 0.
  - A same-cycle lookup misses.
- Replacement, WAYS=2:
  - Fill one set with A (way 0) and then B (way 1), which differ only in tag. Re-update A.
  - Update C into the same set: it evicts B (way 1).
  - Lookups: A hits, B misses, C hits on way 1.
- Clear:
  - update_clear on an existing entry: the following lookup misses, and other ways of the set still hit.
  - update_clear on an absent entry: no change.
- Stall:
  - Response to a hit, then stall = 1 for 3 cycles with lookups presented.
  - Outputs hold; the held lookups are not accepted.
  - After stall drops, the next accepted lookup responds after 1 cycle.
- Flush:
  - With 4 valid entries, pulse flush_req; pulse it again 50 cycles later.
  - busy falls exactly SETS cycles after the second pulse.
  - All 4 entries miss afterwards.

Source files
------------

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: registered one-cycle lookup with stall hold,
// pseudo-LRU replacement, per-entry invalidation and a one-set-per-cycle clearing sweep.
module btb_assoc #(
    parameter int SETS  = 256,
    parameter int WAYS  = 2,
    parameter int TAG_W = 12,
    localparam int IDX_W = $clog2(SETS),
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_lookup_valid,
    input  logic [31:0]      i_lookup_pc,
    input  logic             i_stall,
    output logic             o_resp_valid,
    output logic             o_resp_hit,
    output logic [31:0]      o_resp_target,
    output logic [WAY_W-1:0] o_resp_way,
    input  logic             i_update_en,
    input  logic [31:0]      i_update_pc,
    input  logic [31:0]      i_update_target,
    input  logic             i_update_clear,
    input  logic             i_flush_req,
    output logic             o_busy
);
    typedef enum logic {ST_SWEEP = 1'b0, ST_IDLE = 1'b1} state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_cnt;

    // Entry storage carries no reset; the sweep is the only thing that makes it trustworthy.
    logic [WAYS-1:0]  r_vld  [SETS];
    logic [2:0]       r_plru [SETS];
    logic [TAG_W-1:0] r_tag  [SETS][WAYS];
    logic [31:0]      r_tgt  [SETS][WAYS];

    logic             r_resp_valid;
    logic             r_resp_hit;
    logic [31:0]      r_resp_target;
    logic [WAY_W-1:0] r_resp_way;

    logic [IDX_W-1:0] w_lk_idx, w_up_idx;
    logic [TAG_W-1:0] w_lk_tag, w_up_tag;
    logic [WAYS-1:0]  w_lk_match, w_up_match;
    logic             w_lk_hit, w_up_hit, w_up_inv, w_up_do;
    logic [WAY_W-1:0] w_lk_way, w_up_hway, w_up_iway, w_up_way;
    logic [31:0]      w_lk_tgt;
    logic             w_unused;

    assign w_lk_idx = i_lookup_pc[IDX_W+1:2];
    assign w_lk_tag = i_lookup_pc[IDX_W+2 +: TAG_W];
    assign w_up_idx = i_update_pc[IDX_W+1:2];
    assign w_up_tag = i_update_pc[IDX_W+2 +: TAG_W];
    assign w_unused = ^{i_lookup_pc, i_update_pc};

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
            assign w_lk_match[gi] = r_vld[w_lk_idx][gi] && (r_tag[w_lk_idx][gi] == w_lk_tag);
            assign w_up_match[gi] = r_vld[w_up_idx][gi] && (r_tag[w_up_idx][gi] == w_up_tag);
        end
    endgenerate

    function automatic logic [WAY_W-1:0] plru_victim(input logic [2:0] p);
        logic [1:0] v;
        v = 2'd0;
        if (WAYS == 4)
            v = p[0] ? {1'b1, p[2]} : {1'b0, p[1]};
        else if (WAYS == 2)
            v = {1'b0, p[0]};
        return v[WAY_W-1:0];
    endfunction

    // Tree bits point toward the LRU side: p[0] root, p[1] ways 0/1, p[2] ways 2/3.
    function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] w);
        logic [2:0] n;
        n = p;
        if (WAYS == 4) begin
            n[0] = ~w[1];
            if (w[1]) n[2] = ~w[0];
            else      n[1] = ~w[0];
        end else if (WAYS == 2) begin
            n = {2'b00, ~w[0]};
        end else begin
            n = 3'b000;
        end
        return n;
    endfunction

    // Descending scans so the lowest matching / lowest invalid way wins.
    always_comb begin
        w_lk_hit  = 1'b0;
        w_lk_way  = '0;
        w_lk_tgt  = '0;
        w_up_hit  = 1'b0;
        w_up_hway = '0;
        w_up_inv  = 1'b0;
        w_up_iway = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_lk_match[w]) begin
                w_lk_hit = 1'b1;
                w_lk_way = WAY_W'(w);
                w_lk_tgt = r_tgt[w_lk_idx][w];
            end
            if (w_up_match[w]) begin
                w_up_hit  = 1'b1;
                w_up_hway = WAY_W'(w);
            end
            if (!r_vld[w_up_idx][w]) begin
                w_up_inv  = 1'b1;
                w_up_iway = WAY_W'(w);
            end
        end
    end

    assign w_up_way = w_up_hit ? w_up_hway : (w_up_inv ? w_up_iway : plru_victim(r_plru[w_up_idx]));
    assign w_up_do  = i_update_en && (r_state == ST_IDLE) && !i_flush_req;

    always_ff @(posedge i_clk) begin
        if (r_state == ST_SWEEP) begin
            r_vld[r_cnt]  <= '0;
            r_plru[r_cnt] <= '0;
        end else if (w_up_do) begin
            if (i_update_clear) begin
                if (w_up_hit) r_vld[w_up_idx][w_up_hway] <= 1'b0;
            end else begin
                r_vld[w_up_idx][w_up_way] <= 1'b1;
                r_tag[w_up_idx][w_up_way] <= w_up_tag;
                r_tgt[w_up_idx][w_up_way] <= i_update_target;
                r_plru[w_up_idx]          <= plru_touch(r_plru[w_up_idx], 2'(w_up_way));
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_SWEEP;
            r_cnt   <= '0;
        end else if (i_flush_req) begin
            r_state <= ST_SWEEP;
            r_cnt   <= '0;
        end else if (r_state == ST_SWEEP) begin
            if (r_cnt == IDX_W'(SETS - 1)) r_state <= ST_IDLE;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_resp_valid  <= 1'b0;
            r_resp_hit    <= 1'b0;
            r_resp_target <= '0;
            r_resp_way    <= '0;
        end else if (!i_stall) begin
            r_resp_valid  <= i_lookup_valid;
            r_resp_hit    <= i_lookup_valid && w_lk_hit && (r_state == ST_IDLE);
            r_resp_target <= (i_lookup_valid && w_lk_hit && (r_state == ST_IDLE)) ? w_lk_tgt : '0;
            r_resp_way    <= (i_lookup_valid && w_lk_hit && (r_state == ST_IDLE)) ? w_lk_way : '0;
        end
    end

    assign o_resp_valid  = r_resp_valid;
    assign o_resp_hit    = r_resp_hit;
    assign o_resp_target = r_resp_target;
    assign o_resp_way    = r_resp_way;
    assign o_busy        = (r_state == ST_SWEEP);

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc (SETS=256, WAYS=2, TAG_W=12); one task per scenario.
module tb_btb_assoc;
    localparam int SETS = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        stall = 1'b0;
    logic        update_en = 1'b0;
    logic [31:0] update_pc = '0;
    logic [31:0] update_target = '0;
    logic        update_clear = 1'b0;
    logic        flush_req = 1'b0;
    logic        resp_valid, resp_hit, resp_way, busy;
    logic [31:0] resp_target;

    int n_pass = 0;
    int n_total = 0;

    // Same index 0x80, tags 4 / 8 / 12 / 16.
    localparam logic [31:0] PC_A = 32'h0000_1200, PC_B = 32'h0000_2200;
    localparam logic [31:0] PC_C = 32'h0000_3200, PC_D = 32'h0000_4200;
    localparam logic [31:0] PC_E = 32'h0000_0040, PC_U = 32'h1C00_0100;

    btb_assoc #(.SETS(SETS), .WAYS(2), .TAG_W(12)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_lookup_valid(lookup_valid), .i_lookup_pc(lookup_pc), .i_stall(stall),
        .o_resp_valid(resp_valid), .o_resp_hit(resp_hit),
        .o_resp_target(resp_target), .o_resp_way(resp_way),
        .i_update_en(update_en), .i_update_pc(update_pc),
        .i_update_target(update_target), .i_update_clear(update_clear),
        .i_flush_req(flush_req), .o_busy(busy)
    );

    always #5 clk = ~clk;

    wire [34:0] resp = {resp_valid, resp_hit, resp_way, resp_target};

    function automatic logic [34:0] rsp(input logic v, input logic h, input logic w, input logic [31:0] t);
        return {v, h, w, t};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt, input logic clr);
        update_en = 1'b1; update_pc = pc; update_target = tgt; update_clear = clr;
        step();
        update_en = 1'b0; update_clear = 1'b0;
    endtask

    task automatic do_lookup(input logic [31:0] pc);
        lookup_valid = 1'b1; lookup_pc = pc;
        step();
        lookup_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_total++;
        if ({resp, busy} !== {35'h0, 1'b1}) $display("FAIL reset_values: got resp=%h busy=%b expected resp=0 busy=1", resp, busy);
        else n_pass++;
        repeat (3) step();
        rst_n = 1'b1;
        for (int k = 1; k <= SETS; k++) begin
            if (k == 10) begin
                lookup_valid = 1'b1; lookup_pc = 32'h1C00_0000;
                update_en = 1'b1; update_pc = 32'h1C00_0000; update_target = 32'h1234_5678;
            end
            step();
            if (k == 10) begin
                lookup_valid = 1'b0; update_en = 1'b0;
                n_total++;
                if (resp !== rsp(1, 0, 0, 0)) $display("FAIL sweep_lookup: got %h expected %h", resp, rsp(1, 0, 0, 0));
                else n_pass++;
            end
            if (k == 11) begin
                n_total++;
                if (resp !== 35'h0) $display("FAIL resp_idle: got %h expected 0", resp);
                else n_pass++;
            end
            if (k == SETS - 1) begin
                n_total++;
                if (busy !== 1'b1) $display("FAIL busy_before_end: got %b expected 1", busy);
                else n_pass++;
            end
        end
        n_total++;
        if (busy !== 1'b0) $display("FAIL busy_fall: got %b expected 0", busy);
        else n_pass++;
        do_lookup(32'h1C00_0000);
        n_total++;
        if (resp !== rsp(1, 0, 0, 0)) $display("FAIL busy_update_dropped: got %h expected %h", resp, rsp(1, 0, 0, 0));
        else n_pass++;
        $display("test_reset done");
    endtask

    task automatic test_update();
        update_en = 1'b1; update_pc = PC_U; update_target = 32'h1C00_0800;
        lookup_valid = 1'b1; lookup_pc = PC_U;
        step();
        update_en = 1'b0;
        n_total++;
        if (resp !== rsp(1, 0, 0, 0)) $display("FAIL same_cycle_miss: got %h expected %h", resp, rsp(1, 0, 0, 0));
        else n_pass++;
        step();
        lookup_valid = 1'b0;
        n_total++;
        if (resp !== rsp(1, 1, 0, 32'h1C00_0800)) $display("FAIL update_hit: got %h expected %h", resp, rsp(1, 1, 0, 32'h1C00_0800));
        else n_pass++;
        $display("test_update done");
    endtask

    task automatic test_replacement();
        do_update(PC_A, 32'h0000_A000, 1'b0);
        do_update(PC_B, 32'h0000_B000, 1'b0);
        do_update(PC_A, 32'h0000_A000, 1'b0);
        do_update(PC_C, 32'h0000_C000, 1'b0);
        do_lookup(PC_A);
        n_total++;
        if (resp !== rsp(1, 1, 0, 32'hA000)) $display("FAIL repl_A: got %h expected %h", resp, rsp(1, 1, 0, 32'hA000));
        else n_pass++;
        do_lookup(PC_B);
        n_total++;
        if (resp !== rsp(1, 0, 0, 0)) $display("FAIL repl_B_evicted: got %h expected %h", resp, rsp(1, 0, 0, 0));
        else n_pass++;
        do_lookup(PC_C);
        n_total++;
        if (resp !== rsp(1, 1, 1, 32'hC000)) $display("FAIL repl_C: got %h expected %h", resp, rsp(1, 1, 1, 32'hC000));
        else n_pass++;
        $display("test_replacement done");
    endtask

    task automatic test_clear();
        do_update(PC_C, 32'h0, 1'b1);
        do_lookup(PC_C);
        n_total++;
        if (resp !== rsp(1, 0, 0, 0)) $display("FAIL clear_C: got %h expected %h", resp, rsp(1, 0, 0, 0));
        else n_pass++;
        do_lookup(PC_A);
        n_total++;
        if (resp !== rsp(1, 1, 0, 32'hA000)) $display("FAIL clear_keeps_A: got %h expected %h", resp, rsp(1, 1, 0, 32'hA000));
        else n_pass++;
        do_update(PC_B, 32'h0000_BBBB, 1'b1);
        do_lookup(PC_B);
        n_total++;
        if (resp !== rsp(1, 0, 0, 0)) $display("FAIL clear_absent_B: got %h expected %h", resp, rsp(1, 0, 0, 0));
        else n_pass++;
        do_lookup(PC_A);
        n_total++;
        if (resp !== rsp(1, 1, 0, 32'hA000)) $display("FAIL clear_absent_A: got %h expected %h", resp, rsp(1, 1, 0, 32'hA000));
        else n_pass++;
        // PLRU still points at way 0, but the invalid way 1 must be chosen first.
        do_update(PC_D, 32'h0000_D000, 1'b0);
        do_lookup(PC_D);
        n_total++;
        if (resp !== rsp(1, 1, 1, 32'hD000)) $display("FAIL invalid_first: got %h expected %h", resp, rsp(1, 1, 1, 32'hD000));
        else n_pass++;
        $display("test_clear done");
    endtask

    task automatic test_stall();
        lookup_valid = 1'b1; lookup_pc = PC_A;
        step();
        stall = 1'b1; lookup_pc = PC_D;
        for (int k = 0; k < 3; k++) begin
            step();
            n_total++;
            if (resp !== rsp(1, 1, 0, 32'hA000)) $display("FAIL stall_hold_%0d: got %h expected %h", k, resp, rsp(1, 1, 0, 32'hA000));
            else n_pass++;
        end
        stall = 1'b0;
        step();
        lookup_valid = 1'b0;
        n_total++;
        if (resp !== rsp(1, 1, 1, 32'hD000)) $display("FAIL stall_release: got %h expected %h", resp, rsp(1, 1, 1, 32'hD000));
        else n_pass++;
        step();
        n_total++;
        if (resp !== 35'h0) $display("FAIL stall_idle: got %h expected 0", resp);
        else n_pass++;
        $display("test_stall done");
    endtask

    task automatic test_flush();
        do_update(PC_E, 32'h0000_E000, 1'b0);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        repeat (49) step();
        n_total++;
        if (busy !== 1'b1) $display("FAIL flush_busy: got %b expected 1", busy);
        else n_pass++;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        repeat (SETS - 1) step();
        n_total++;
        if (busy !== 1'b1) $display("FAIL reflush_busy_hold: got %b expected 1", busy);
        else n_pass++;
        step();
        n_total++;
        if (busy !== 1'b0) $display("FAIL reflush_busy_fall: got %b expected 0", busy);
        else n_pass++;
        do_lookup(PC_U);
        n_total++;
        if (resp !== rsp(1, 0, 0, 0)) $display("FAIL flush_U: got %h expected %h", resp, rsp(1, 0, 0, 0));
        else n_pass++;
        do_lookup(PC_A);
        n_total++;
        if (resp !== rsp(1, 0, 0, 0)) $display("FAIL flush_A: got %h expected %h", resp, rsp(1, 0, 0, 0));
        else n_pass++;
        do_lookup(PC_D);
        n_total++;
        if (resp !== rsp(1, 0, 0, 0)) $display("FAIL flush_D: got %h expected %h", resp, rsp(1, 0, 0, 0));
        else n_pass++;
        do_lookup(PC_E);
        n_total++;
        if (resp !== rsp(1, 0, 0, 0)) $display("FAIL flush_E: got %h expected %h", resp, rsp(1, 0, 0, 0));
        else n_pass++;
        $display("test_flush done");
    endtask

    task automatic test_reset_mid();
        int cycles;
        do_update(PC_A, 32'h0000_A000, 1'b0);
        lookup_valid = 1'b1; lookup_pc = PC_A;
        step();
        lookup_valid = 1'b0;
        n_total++;
        if (resp !== rsp(1, 1, 0, 32'hA000)) $display("FAIL pre_reset_hit: got %h expected %h", resp, rsp(1, 1, 0, 32'hA000));
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({resp, busy} !== {35'h0, 1'b1}) $display("FAIL mid_reset: got resp=%h busy=%b expected resp=0 busy=1", resp, busy);
        else n_pass++;
        step();
        rst_n = 1'b1;
        cycles = 0;
        while (busy === 1'b1 && cycles < 2 * SETS) begin
            step();
            cycles++;
        end
        n_total++;
        if (cycles !== SETS) $display("FAIL mid_reset_sweep_len: got %0d expected %0d", cycles, SETS);
        else n_pass++;
        do_lookup(PC_A);
        n_total++;
        if (resp !== rsp(1, 0, 0, 0)) $display("FAIL mid_reset_A: got %h expected %h", resp, rsp(1, 0, 0, 0));
        else n_pass++;
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_update();
        test_replacement();
        test_clear();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
